// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants, opcode/state enums and instruction fields
// for the ALU issue sequencer.
package alu_seq_pkg;

  localparam int DATA_W    = 16;
  localparam int NREGS     = 8;
  localparam int REG_IDX_W = 3;
  localparam int OP_W      = 3;
  localparam int IMM_W     = 10;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_MSB = 9;
  localparam int IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_SUB  = 3'b000,
    OP_ADD  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV3 = 3'b011,
    OP_AND  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_LDI  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic [DATA_W-1:0] ldi_ext(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8x16 register file, two async read ports, one sync write port.
// Optional macro ALU_SEQ_R0_ZERO_EN hardwires R0 to zero.
module alu_regfile
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]    rs1_data,
  output logic [DATA_W-1:0]    rs2_data,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wd_addr,
  input  logic [DATA_W-1:0]    wd_data
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_ok;

`ifdef ALU_SEQ_R0_ZERO_EN
  assign wr_ok    = we && (wd_addr != '0);
  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
`else
  assign wr_ok    = we;
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
`endif

  // Storage: cleared on reset, single write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wd_addr] <= wd_data;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: 3-state issue controller feeding an external ALU.
// Optional macro ALU_SEQ_R0_ZERO_EN makes R0 read as zero.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_zero,
  output logic [2:0]        out_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  state_e                 state;
  op_e                    op_q;
  logic [REG_IDX_W-1:0]   rd_q;
  logic [IMM_W-1:0]       imm_q;

  logic [REG_IDX_W-1:0]   rs1;
  logic [REG_IDX_W-1:0]   rs2;
  logic [DATA_W-1:0]      rs1_data;
  logic [DATA_W-1:0]      rs2_data;
  logic [DATA_W-1:0]      wb_data;
  logic                   wb_zero;
  logic                   accept;
  logic                   in_exec;

  assign rs1      = in_instr[RS1_MSB:RS1_LSB];
  assign rs2      = in_instr[RS2_MSB:RS2_LSB];
  assign in_ready = (state == S_IDLE);
  assign out_valid = (state == S_RESP);
  assign accept   = in_ready && in_valid;
  assign in_exec  = (state == S_EXEC);

  assign wb_data = (op_q == OP_LDI) ? ldi_ext(imm_q) : alu_result;
  assign wb_zero = (op_q == OP_LDI) ? (imm_q == '0) : alu_zero;

  alu_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (in_exec),
    .wd_addr  (rd_q),
    .wd_data  (wb_data)
  );

  // Control: IDLE -> EXEC -> RESP, leave RESP when consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (in_valid) state <= S_EXEC;
        S_EXEC: state <= S_RESP;
        S_RESP: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand issue on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_SUB;
      rd_q     <= '0;
      imm_q    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
    end else if (accept) begin
      op_q     <= op_e'(in_instr[OP_MSB:OP_LSB]);
      rd_q     <= in_instr[RD_MSB:RD_LSB];
      imm_q    <= in_instr[IMM_MSB:IMM_LSB];
      alu_a    <= rs1_data;
      alu_b    <= rs2_data;
      alu_ctrl <= in_instr[OP_MSB:OP_LSB];
    end
  end

  // Result capture in EXEC, held through RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_zero <= 1'b0;
      out_rd   <= '0;
    end else if (in_exec) begin
      out_data <= wb_data;
      out_zero <= wb_zero;
      out_rd   <= rd_q;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench with a behavioural ALU.
// Honours ALU_SEQ_R0_ZERO_EN for the R0 expectations.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_zero;
  logic [2:0]  out_rd;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [15:0] alu_result;
  logic        alu_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_rd     (out_rd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  // Behavioural ALU driven by the sequencer
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000:  alu_result = alu_a - alu_b;
      3'b001:  alu_result = alu_a + alu_b;
      3'b010:  alu_result = alu_a * alu_b;
      3'b011:  alu_result = alu_a / 16'd3;
      3'b100:  alu_result = alu_a & alu_b;
      3'b101:  alu_result = alu_a << 1;
      3'b110:  alu_result = alu_a >> 1;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  function automatic logic [15:0] rr(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return {op, rd, s1, s2, 4'b0000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
    return {3'b111, rd, imm};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one instruction in IDLE; returns at the negedge inside EXEC
  task automatic send(input logic [15:0] instr);
    logic [2:0] op;
    op = instr[15:13];
    @(negedge clk);
    check("in_ready_idle", {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = '0;
    check("in_ready_exec", {15'd0, in_ready}, 16'd0);
    check("alu_ctrl_exec", {13'd0, alu_ctrl}, {13'd0, op});
  endtask

  // Observe RESP for hold+1 cycles, optionally injecting a stray instruction
  task automatic resp(input logic [15:0] d, input logic z, input logic [2:0] rd,
                      input int hold, input bit inject);
    out_ready = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      if (inject && i == 1) begin
        in_valid = 1'b1;
        in_instr = ldi(3'd1, 10'h055);
      end
      if (inject && i == 2) begin
        in_valid = 1'b0;
        in_instr = '0;
      end
      check("out_valid_resp", {15'd0, out_valid}, 16'd1);
      check("in_ready_resp", {15'd0, in_ready}, 16'd0);
      check("out_data", out_data, d);
      check("out_zero", {15'd0, out_zero}, {15'd0, z});
      check("out_rd", {13'd0, out_rd}, {13'd0, rd});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", {15'd0, out_valid}, 16'd0);
    check("in_ready_back", {15'd0, in_ready}, 16'd1);
  endtask

  task automatic op1(input logic [15:0] instr, input logic [15:0] d,
                     input logic z, input logic [2:0] rd);
    send(instr);
    resp(d, z, rd, 0, 1'b0);
  endtask

  initial begin
    #2;
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_alu_a", alu_a, 16'd0);
    check("rst_alu_b", alu_b, 16'd0);
    check("rst_alu_ctrl", {13'd0, alu_ctrl}, 16'd0);
    check("rst_out_data", out_data, 16'd0);
    check("rst_out_zero", {15'd0, out_zero}, 16'd0);
    check("rst_out_rd", {13'd0, out_rd}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    op1(ldi(3'd1, 10'd5), 16'h0005, 1'b0, 3'd1);
    op1(ldi(3'd2, 10'd3), 16'h0003, 1'b0, 3'd2);
    op1(rr(3'b001, 3'd3, 3'd1, 3'd2), 16'h0008, 1'b0, 3'd3);
    op1(rr(3'b000, 3'd4, 3'd1, 3'd1), 16'h0000, 1'b1, 3'd4);
    op1(rr(3'b100, 3'd5, 3'd4, 3'd1), 16'h0000, 1'b1, 3'd5);
    op1(rr(3'b010, 3'd6, 3'd1, 3'd2), 16'h000F, 1'b0, 3'd6);

    send(rr(3'b001, 3'd3, 3'd1, 3'd2));
    resp(16'h0008, 1'b0, 3'd3, 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_extra_resp", {15'd0, out_valid}, 16'd0);
    end
    op1(rr(3'b001, 3'd3, 3'd1, 3'd2), 16'h0008, 1'b0, 3'd3);

    send(rr(3'b001, 3'd3, 3'd1, 3'd2));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("mid_rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("mid_rst_alu_a", alu_a, 16'd0);
    check("mid_rst_alu_b", alu_b, 16'd0);
    check("mid_rst_alu_ctrl", {13'd0, alu_ctrl}, 16'd0);
    check("mid_rst_out_data", out_data, 16'd0);
    check("mid_rst_out_rd", {13'd0, out_rd}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    op1(rr(3'b001, 3'd6, 3'd3, 3'd3), 16'h0000, 1'b1, 3'd6);

    op1(ldi(3'd0, 10'd7), 16'h0007, 1'b0, 3'd0);
`ifdef ALU_SEQ_R0_ZERO_EN
    op1(rr(3'b001, 3'd1, 3'd0, 3'd0), 16'h0000, 1'b1, 3'd1);
`else
    op1(rr(3'b001, 3'd1, 3'd0, 3'd0), 16'h000E, 1'b0, 3'd1);
`endif

    op1(ldi(3'd2, 10'h3FF), 16'h03FF, 1'b0, 3'd2);
    op1(ldi(3'd2, 10'h000), 16'h0000, 1'b1, 3'd2);

    op1(ldi(3'd1, 10'h3FF), 16'h03FF, 1'b0, 3'd1);
    op1(rr(3'b010, 3'd3, 3'd1, 3'd1), 16'hF801, 1'b0, 3'd3);

    op1(ldi(3'd4, 10'd100), 16'd100, 1'b0, 3'd4);
    op1(rr(3'b011, 3'd5, 3'd4, 3'd2), 16'd33, 1'b0, 3'd5);
    op1(rr(3'b101, 3'd6, 3'd4, 3'd2), 16'd200, 1'b0, 3'd6);
    op1(rr(3'b110, 3'd7, 3'd4, 3'd2), 16'd50, 1'b0, 3'd7);
    op1(rr(3'b000, 3'd7, 3'd7, 3'd5), 16'd17, 1'b0, 3'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
